// File: rtl/ws2812_strip_ctrl_if.sv
// Wishbone classic slave bundle between the user-area bus and the WS2812 strip controller.
interface ws2812_strip_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/ws2812_strip_ctrl.sv
// Streams a Wishbone-written pixel buffer to a WS2812 chain with latch gap and end-of-frame IRQ.
// IDLE wait START | LOAD fetch pixel[idx] | HIGH drive 1 | LOW drive 0, finish bit | LATCH reset gap
module ws2812_strip_ctrl #(
    parameter int          NUM_LEDS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          T0H       = 20,
    parameter int          T1H       = 40,
    parameter int          TBIT      = 63,
    parameter int          TRESET    = 2500
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    ws2812_strip_ctrl_if.slave  wb,
    output logic                led_o,
    output logic                led_oeb,
    output logic                busy_o,
    output logic                irq_o
);
    localparam int LW   = $clog2(NUM_LEDS) + 1;
    localparam int IW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int TMAX = (TRESET > TBIT) ? TRESET : TBIT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] C_BIT = TW'(TBIT - 1);
    localparam logic [TW-1:0] C_RST = TW'(TRESET - 1);
    localparam logic [TW-1:0] C_H0  = TW'(TBIT - T0H);
    localparam logic [TW-1:0] C_H1  = TW'(TBIT - T1H);
    localparam logic [LW-1:0] C_NUM = LW'(NUM_LEDS);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HIGH, S_LOW, S_LATCH} state_t;
    state_t r_state, w_next;

    logic          r_ack;
    logic [31:0]   r_dat;
    logic          r_irq_en, r_auto, r_done;
    logic [LW-1:0] r_len;
    logic [23:0]   r_pix [NUM_LEDS];
    logic [23:0]   r_shift;
    logic [4:0]    r_bitcnt;
    logic [IW-1:0] r_idx;
    logic [TW-1:0] r_tmr;

    logic          w_valid, w_acc, w_wr, w_is_pix, w_ctrl_wr, w_stat_wr;
    logic [7:0]    w_off;
    logic [5:0]    w_pidx;
    logic [31:0]   w_rdata;
    logic [LW-1:0] w_len_wr, w_idx_p1;
    logic          w_start, w_done_set, w_shift, w_idx_clr, w_idx_inc;
    logic          w_unused;

    assign w_valid   = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_acc     = w_valid & ~r_ack;
    assign w_wr      = w_acc & wb.wbs_we_i;
    assign w_off     = wb.wbs_adr_i[7:0];
    assign w_pidx    = wb.wbs_adr_i[7:2] - 6'd16;
    assign w_is_pix  = (wb.wbs_adr_i[7:6] != 2'b00) && (wb.wbs_adr_i[1:0] == 2'b00)
                       && ({26'b0, w_pidx} < 32'(NUM_LEDS));
    assign w_ctrl_wr = w_wr && (w_off == 8'h00) && wb.wbs_sel_i[0];
    assign w_stat_wr = w_wr && (w_off == 8'h04) && wb.wbs_sel_i[0];
    assign w_start   = w_ctrl_wr && wb.wbs_dat_i[0] && (r_state == S_IDLE);
    assign w_len_wr  = (wb.wbs_dat_i > 32'(NUM_LEDS)) ? C_NUM : wb.wbs_dat_i[LW-1:0];
    assign w_idx_p1  = LW'(r_idx) + 1'b1;
    assign w_unused  = wb.wbs_sel_i[3];

    always_comb begin
        w_rdata = '0;
        if (w_is_pix) begin
            w_rdata = {8'h00, r_pix[w_pidx[IW-1:0]]};
        end else begin
            case (w_off)
                8'h00:   w_rdata = {29'b0, r_auto, r_irq_en, 1'b0};
                8'h04:   w_rdata = {30'b0, r_done, busy_o};
                8'h08:   w_rdata = 32'(r_len);
                default: w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_irq_en <= 1'b0;
            r_auto   <= 1'b0;
            r_done   <= 1'b0;
            r_len    <= C_NUM;
            for (int i = 0; i < NUM_LEDS; i++) r_pix[i] <= '0;
        end else begin
            r_ack <= w_acc;
            if (w_acc) r_dat <= w_rdata;
            if (w_ctrl_wr) begin
                r_irq_en <= wb.wbs_dat_i[1];
                r_auto   <= wb.wbs_dat_i[2];
            end
            if (w_wr && (w_off == 8'h08)) r_len <= w_len_wr;
            if (w_wr && w_is_pix) begin
                if (wb.wbs_sel_i[0]) r_pix[w_pidx[IW-1:0]][7:0]   <= wb.wbs_dat_i[7:0];
                if (wb.wbs_sel_i[1]) r_pix[w_pidx[IW-1:0]][15:8]  <= wb.wbs_dat_i[15:8];
                if (wb.wbs_sel_i[2]) r_pix[w_pidx[IW-1:0]][23:16] <= wb.wbs_dat_i[23:16];
            end
            // end-of-frame set takes priority over a same-cycle W1C
            if (w_done_set) r_done <= 1'b1;
            else if (w_start || (w_stat_wr && wb.wbs_dat_i[1])) r_done <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_done_set = 1'b0;
        w_shift    = 1'b0;
        w_idx_clr  = 1'b0;
        w_idx_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_idx_clr = 1'b1;
                    w_next    = (r_len == '0) ? S_LATCH : S_LOAD;
                end
            end
            S_LOAD: w_next = S_HIGH;
            S_HIGH: begin
                if (r_tmr == (r_shift[23] ? C_H1 : C_H0)) w_next = S_LOW;
            end
            S_LOW: begin
                // the following LOAD cycle is borrowed from this bit's low time
                if (r_bitcnt != 5'd0) begin
                    if (r_tmr == '0) begin
                        w_shift = 1'b1;
                        w_next  = S_HIGH;
                    end
                end else if (w_idx_p1 < r_len) begin
                    if (r_tmr <= TW'(1)) begin
                        w_idx_inc = 1'b1;
                        w_next    = S_LOAD;
                    end
                end else if (r_tmr == '0) begin
                    w_next = S_LATCH;
                end
            end
            S_LATCH: begin
                if (r_tmr == '0) begin
                    w_done_set = 1'b1;
                    if (r_auto) begin
                        w_idx_clr = 1'b1;
                        w_next    = S_LOAD;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tmr    <= '0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_idx    <= '0;
        end else begin
            if (w_next == S_HIGH && r_state != S_HIGH)        r_tmr <= C_BIT;
            else if (w_next == S_LATCH && r_state != S_LATCH) r_tmr <= C_RST;
            else if (r_tmr != '0)                             r_tmr <= r_tmr - 1'b1;
            if (r_state == S_LOAD) begin
                r_shift  <= r_pix[r_idx];
                r_bitcnt <= 5'd23;
            end else if (w_shift) begin
                r_shift  <= {r_shift[22:0], 1'b0};
                r_bitcnt <= r_bitcnt - 1'b1;
            end
            if (w_idx_clr)      r_idx <= '0;
            else if (w_idx_inc) r_idx <= r_idx + 1'b1;
        end
    end

    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat;
    assign led_o        = (r_state == S_HIGH);
    assign led_oeb      = 1'b0;
    assign busy_o       = (r_state != S_IDLE);
    assign irq_o        = r_done & r_irq_en;
endmodule
